// File: rtl/cpu_reg_responder.sv
// cpu_reg_responder: CPU-slave register block with a fixed, parameterised
// response latency.
//
// Ports
//   cpu_s_clk              clock, rising edge
//   cpu_s_reset            synchronous active-high reset
//   cpu_s_write/read       request strobes (write wins when both are set)
//   cpu_s_address          byte address; bits [1:0] ignored
//   cpu_s_write_data       write data
//   cpu_s_read_data        response data, valid with cpu_s_access_complete
//   cpu_s_access_ready     request accepted this cycle when valid
//   cpu_s_access_complete  one-cycle response pulse
//   reg_out                flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   decode_error           one-cycle pulse with complete for an unmapped access
module cpu_reg_responder #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] DECODE_ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF)
) (
  input  logic                           cpu_s_clk,
  input  logic                           cpu_s_reset,
  input  logic                           cpu_s_write,
  input  logic                           cpu_s_read,
  input  logic [ADDR_WIDTH-1:0]          cpu_s_address,
  input  logic [DATA_WIDTH-1:0]          cpu_s_write_data,
  output logic [DATA_WIDTH-1:0]          cpu_s_read_data,
  output logic                           cpu_s_access_ready,
  output logic                           cpu_s_access_complete,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic                           decode_error
);

  localparam int unsigned WORD_W = ADDR_WIDTH - 2;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_err;

  logic [WORD_W-1:0]     word;
  logic [IDX_W-1:0]      idx;
  logic                  mapped;
  logic                  accept;
  logic [DATA_WIDTH-1:0] acc_data;

  // Any set bit above the index field pushes the word past NUM_REGS.
  assign word   = cpu_s_address[ADDR_WIDTH-1:2];
  assign idx    = word[IDX_W-1:0];
  assign mapped = (word < WORD_W'(NUM_REGS));

  // Decoded from state and reset so ready is low during reset and high in
  // the very first cycle after release.
  assign cpu_s_access_ready = (state == ST_IDLE) && !cpu_s_reset;
  assign accept = (cpu_s_write | cpu_s_read) & cpu_s_access_ready;

  // Response data fixed at accept: zero for writes, register or error word for reads.
  always_comb begin
    acc_data = '0;
    if (!cpu_s_write) begin
      acc_data = mapped ? regs[idx] : DECODE_ERR_DATA;
    end
  end

  // Flatten the register file.
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  // Control FSM, register file and registered response outputs.
  always_ff @(posedge cpu_s_clk) begin
    if (cpu_s_reset) begin
      state                 <= ST_IDLE;
      cnt                   <= '0;
      hold_data             <= '0;
      hold_err              <= 1'b0;
      cpu_s_read_data       <= '0;
      cpu_s_access_complete <= 1'b0;
      decode_error          <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      cpu_s_access_complete <= 1'b0;
      decode_error          <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hold_data <= acc_data;
            hold_err  <= !mapped;
            if (cpu_s_write && mapped) begin
              regs[idx] <= cpu_s_write_data;
            end
            // Zero-wait builds respond straight from the accept-time values.
            if (WAIT_CYCLES == 0) begin
              state                 <= ST_RESP;
              cpu_s_access_complete <= 1'b1;
              cpu_s_read_data       <= acc_data;
              decode_error          <= !mapped;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state                 <= ST_RESP;
            cpu_s_access_complete <= 1'b1;
            cpu_s_read_data       <= hold_data;
            decode_error          <= hold_err;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_reg_responder.sv
// Directed bench for cpu_reg_responder: a default build (WAIT_CYCLES=2) and a
// zero-wait build share the clock and reset.
module tb_cpu_reg_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         write = 1'b0, read = 1'b0;
  logic [31:0]  address = '0, wdata = '0;
  logic [31:0]  rdata;
  logic         ready, complete, derr;
  logic [511:0] reg_out;

  logic         z_write = 1'b0, z_read = 1'b0;
  logic [31:0]  z_address = '0, z_wdata = '0;
  logic [31:0]  z_rdata;
  logic         z_ready, z_complete, z_derr;
  logic [511:0] z_reg_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  cpu_reg_responder dut (
    .cpu_s_clk(clk), .cpu_s_reset(rst), .cpu_s_write(write), .cpu_s_read(read),
    .cpu_s_address(address), .cpu_s_write_data(wdata), .cpu_s_read_data(rdata),
    .cpu_s_access_ready(ready), .cpu_s_access_complete(complete),
    .reg_out(reg_out), .decode_error(derr)
  );

  cpu_reg_responder #(.WAIT_CYCLES(0)) dut0 (
    .cpu_s_clk(clk), .cpu_s_reset(rst), .cpu_s_write(z_write), .cpu_s_read(z_read),
    .cpu_s_address(z_address), .cpu_s_write_data(z_wdata), .cpu_s_read_data(z_rdata),
    .cpu_s_access_ready(z_ready), .cpu_s_access_complete(z_complete),
    .reg_out(z_reg_out), .decode_error(z_derr)
  );

  typedef struct {
    logic        w;
    logic        r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string nm);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("%s_reg%0d", nm, i), reg_out[i*32 +: 32], model[i]);
    end
  endtask

  // One complete transaction on the default build, starting from IDLE.
  task automatic access(input vec_t v, input string nm);
    int lat;
    logic [29:0] widx;
    @(negedge clk);
    chk({nm, "_ready_idle"}, 32'(ready), 32'd1);
    write = v.w; read = v.r; address = v.a; wdata = v.d;
    widx = v.a[31:2];
    if (v.w && widx < 30'd16) model[widx[3:0]] = v.d;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk_regs({nm, "_acc1"});
    lat = 1;
    while (!complete && lat < 20) begin
      chk({nm, "_ready_busy"}, 32'(ready), 32'd0);
      chk({nm, "_derr_early"}, 32'(derr), 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd3);
    chk({nm, "_ready_resp"}, 32'(ready), 32'd0);
    chk({nm, "_rdata"}, rdata, v.exp_rd);
    chk({nm, "_derr"}, 32'(derr), 32'(v.exp_er));
  endtask

  initial begin
    int ncomp;
    int first_c;
    vec_t v;

    //        w     r     addr           wdata          exp_rdata      err
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_000B, 32'h0,         32'h1234_5678, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_003C, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_003C, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h8000_0008, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0};

    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_complete", 32'(complete), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_derr", 32'(derr), 32'd0);
    chk_regs("rst");
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      access(vecs[i], $sformatf("vec%0d", i));
    end

    // Request held across three accesses: accepts at cycles 0, 4, 8.
    @(negedge clk);
    chk("held_ready_c0", 32'(ready), 32'd1);
    read = 1'b1; address = 32'h0000_0008;
    ncomp = 0;
    first_c = -1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("held_ready_c%0d", c), 32'(ready), 32'((c >= 12) || (c % 4 == 0)));
      chk($sformatf("held_complete_c%0d", c), 32'(complete), 32'((c <= 11) && (c % 4 == 3)));
      if (complete) begin
        ncomp++;
        if (first_c < 0) first_c = c;
        chk($sformatf("held_rdata_c%0d", c), rdata, 32'h1234_5678);
      end
      if (c == 9) read = 1'b0;
    end
    chk("held_count", 32'(ncomp), 32'd3);
    chk("held_first", 32'(first_c), 32'd3);

    // Reset in the cycle after a read accept discards the access.
    @(negedge clk);
    read = 1'b1; address = 32'h0000_0004;
    @(negedge clk);
    read = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midrst_complete", 32'(complete), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_rdata", rdata, 32'd0);
      chk("midrst_derr", 32'(derr), 32'd0);
      chk_regs("midrst");
    end
    rst = 1'b0;
    #1;
    chk("midrst_release_ready", 32'(ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("midrst_no_complete", 32'(complete), 32'd0);
    end
    v = '{1'b0, 1'b1, 32'h0000_0004, 32'h0, 32'h0000_0000, 1'b0};
    access(v, "post_rst_read");

    // Zero-wait build: write then read, each completing the next cycle.
    @(negedge clk);
    chk("z_ready_idle", 32'(z_ready), 32'd1);
    z_write = 1'b1; z_address = 32'h0000_0004; z_wdata = 32'h0000_0011;
    @(negedge clk);
    z_write = 1'b0;
    chk("z_wr_complete", 32'(z_complete), 32'd1);
    chk("z_wr_ready", 32'(z_ready), 32'd0);
    chk("z_wr_rdata", z_rdata, 32'd0);
    chk("z_wr_reg1", z_reg_out[63:32], 32'h0000_0011);
    @(negedge clk);
    chk("z_wr_ready_again", 32'(z_ready), 32'd1);
    chk("z_wr_complete_off", 32'(z_complete), 32'd0);
    z_read = 1'b1;
    @(negedge clk);
    z_read = 1'b0;
    chk("z_rd_complete", 32'(z_complete), 32'd1);
    chk("z_rd_rdata", z_rdata, 32'h0000_0011);
    chk("z_rd_derr", 32'(z_derr), 32'd0);
    @(negedge clk);
    chk("z_rd_ready_again", 32'(z_ready), 32'd1);
    chk("z_rd_rdata_hold", z_rdata, 32'h0000_0011);
    z_read = 1'b1; z_address = 32'h0000_0100;
    @(negedge clk);
    z_read = 1'b0;
    chk("z_err_complete", 32'(z_complete), 32'd1);
    chk("z_err_rdata", z_rdata, 32'hDEAD_BEEF);
    chk("z_err_derr", 32'(z_derr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
